// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a 1-cycle registered read.
// Writes complete in the accept cycle. Reads hold the bus for one extra cycle while RAM data returns.
module mem_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int RAM_AW     = 8,
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [CNT_W-1:0]  m0_count,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [CNT_W-1:0]  m1_count,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              dbg_state,
    output logic              dbg_last_grant
);
    // Handshake: a requester presents cmd/addr/wdata and holds them until ready=1.
    // ready is combinational. The transfer happens in the cycle where ready=1.
    // Read data follows one cycle later, marked by rvalid.
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic {IDLE = 1'b0, RD = 1'b1} state_t;

    state_t              state, state_next;
    logic                last_grant, rd_owner, rd_oor;
    logic [CNT_W-1:0]    count0, count1;
    logic                req0, req1, grant, winner;
    logic [1:0]          w_cmd;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   rd_data;

    assign req0  = (m0_cmd == MREAD) || (m0_cmd == MWRITE);
    assign req1  = (m1_cmd == MREAD) || (m1_cmd == MWRITE);
    assign grant = (state == IDLE) && !reset && (req0 || req1);

    always_comb begin
        if (req0 && req1)
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        else
            winner = req1;
    end

    assign w_cmd   = winner ? m1_cmd   : m0_cmd;
    assign w_addr  = winner ? m1_addr  : m0_addr;
    assign w_wdata = winner ? m1_wdata : m0_wdata;
    assign rd_data = rd_oor ? '0 : ram_dout;

    always_comb begin
        state_next = state;
        m0_ready   = 1'b0;
        m1_ready   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        ram_addr   = '0;
        ram_write  = 1'b0;
        ram_din    = '0;
        case (state)
            IDLE: begin
                if (grant) begin
                    m0_ready = ~winner;
                    m1_ready = winner;
                    ram_addr = w_addr[RAM_AW-1:0];
                    if (w_cmd == MWRITE) begin
                        // An address above the RAM window is accepted but never written.
                        ram_write = ~w_addr[ADDR_W-1];
                        ram_din   = w_wdata;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                state_next = IDLE;
                if (!reset) begin
                    if (rd_owner) begin
                        m1_rvalid = 1'b1;
                        m1_rdata  = rd_data;
                    end else begin
                        m0_rvalid = 1'b1;
                        m0_rdata  = rd_data;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rd_owner   <= 1'b0;
            rd_oor     <= 1'b0;
            count0     <= '0;
            count1     <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                last_grant <= winner;
                if (winner) begin
                    if (count1 != '1) count1 <= count1 + CNT_W'(1);
                end else begin
                    if (count0 != '1) count0 <= count0 + CNT_W'(1);
                end
                if (w_cmd != MWRITE) begin
                    rd_owner <= winner;
                    rd_oor   <= w_addr[ADDR_W-1];
                end
            end
        end
    end

    // Observed values read as their reset values while reset is held.
    assign m0_count       = reset ? '0 : count0;
    assign m1_count       = reset ? '0 : count1;
    assign dbg_state      = !reset && (state == RD);
    assign dbg_last_grant = reset || last_grant;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single-port 256x16 RAM between the cpu (requester 0) and a second bus master (requester 1, e.g. DMA/IO engine).
- Uses the existing memory command encoding: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10.
- Applies the existing address decode: RAM is selected when addr[8]==0.
- Sits between the requesters and the RAM instance and owns all RAM address, write and data-in pins.

Parameters:
- ADDR_W, 9, requester address width.
- DATA_W, 16, data width.
- RAM_AW, 8, RAM address width (ram_addr = addr[RAM_AW-1:0]).
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins ties.
- CNT_W, 16, width of the per-requester transaction counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- m0_cmd  in  2  requester 0 command (MNONE/MREAD/MWRITE)
- m0_addr  in  9  requester 0 address
- m0_wdata  in  16  requester 0 write data
- m0_ready  out  1  requester 0 command accepted this cycle
- m0_rvalid  out  1  requester 0 read data valid
- m0_rdata  out  16  requester 0 read data
- m0_count  out  CNT_W  accepted transactions for requester 0, saturating
- m1_cmd, m1_addr, m1_wdata, m1_ready, m1_rvalid, m1_rdata, m1_count  same as m0_* for requester 1
- ram_addr  out  8  RAM address
- ram_write  out  1  RAM write enable
- ram_din  out  16  RAM write data
- ram_dout  in  16  RAM read data, registered inside the RAM (1-cycle latency)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- Outputs while reset is high: state=IDLE, last_grant=1, rd_owner=0, rd_oor=0, counters=0. All ready, rvalid and ram_write outputs are 0. ram_addr, ram_din and both rdata outputs are 0.
- Requester protocol:
  - A request is cmd in {MREAD, MWRITE}. cmd=2'b11 is treated as MNONE.
  - The requester holds cmd, addr and wdata stable until it sees ready=1.
  - ready is combinational and valid in the accept cycle.
- FSM states: IDLE, RD.
- IDLE with no request: all outputs are at their reset values.
- IDLE with one or more requests:
  - Pick a winner. With one requester active, it wins.
  - With both active: FIXED_PRIO=1 picks requester 0; otherwise the winner is the requester that is not last_grant.
  - Assert winner_ready=1 and drive ram_addr = winner_addr[7:0].
  - Update last_grant to the winner and increment the winner's count, saturating at all-ones.
- Write accept (IDLE):
  - ram_write = ~addr[8]; ram_din = wdata.
  - State stays IDLE, so back-to-back writes run one per cycle.
- Read accept (IDLE):
  - ram_write = 0.
  - Register rd_owner = winner and rd_oor = addr[8].
  - Next state is RD.
- RD (exactly one cycle):
  - owner_rvalid = 1 and owner_rdata = rd_oor ? 16'h0000 : ram_dout.
  - Both ready outputs are 0 and no grant is issued.
  - The RAM pins return to 0.
  - Next state is IDLE.
- Read latency: data appears 1 cycle after the accept cycle. Sustained read throughput is 1 read per 2 cycles.
- Out-of-range address (addr[8]=1):
  - The request is still accepted and counted.
  - A write is dropped (ram_write stays 0).
  - A read returns 16'h0000 with normal rvalid timing.
- Non-owner outputs: the non-owner's rvalid is 0 and its rdata is 16'h0000 at all times.
- Reset mid-operation: reset asserted in RD suppresses rvalid that cycle, and the pending read is discarded.
- A request that arrives while the FSM is in RD waits and is arbitrated in the next IDLE cycle.
- Starvation bound (round-robin): a continuously requesting master is granted within 2 grant opportunities.

Test Plan:
- Write then read, requester 0: m0 MWRITE addr 9'h005 data 16'hBEEF → same-cycle m0_ready=1, ram_write=1, ram_addr=8'h05. Then m0 MREAD 9'h005 → next cycle m0_rvalid=1, m0_rdata=16'hBEEF, m1_rvalid=0.
- Simultaneous reads after reset, round-robin: both MREAD (m0 9'h010, m1 9'h020) → m0 granted first (last_grant=1 at reset). m1 granted 2 cycles later. Each rvalid arrives one cycle after its own grant. Counts are 1 and 1.
- Continuous contention: both issue MWRITE every cycle for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1. Both counts = 3. No cycle has both ready outputs high.
- Out-of-range access: m1 MWRITE 9'h1FF 16'h1234 → m1_ready=1, ram_write=0. m1 MREAD 9'h100 → m1_rvalid=1, m1_rdata=16'h0000.
- Reset mid-read: m0 read accepted, reset=1 in the following (RD) cycle → m0_rvalid=0. State IDLE, counts=0. The next request is accepted the first cycle after reset deasserts.
- FIXED_PRIO=1 with 2'b11 command: both MREAD each cycle → m0 always wins and m1_count stays 0. m0_cmd=2'b11 → no grant, ram_write=0.
